// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory command signals shared by the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the core
// and memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch port and the data port.
// One access is in flight at a time: IDLE -> ISSUE -> WAIT (LATENCY cycles) -> RESP.
// Ties go to the port that was not granted last.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : gen_bad_latency
    $error("mem_port_arbiter: LATENCY must be in 1..15");
  end

  localparam logic [3:0] LatCnt = 4'(LATENCY);
  localparam logic       PortI  = 1'b0;
  localparam logic       PortD  = 1'b1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic          grant_q;
  logic          last_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] m_addr_q;
  logic          m_we_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          pick_d;
  logic          any_req;

  // Arbitration: D wins alone, or on a tie when I was granted last.
  always_comb begin
    any_req = bus.i_req | bus.d_req;
    pick_d  = bus.d_req & (~bus.i_req | (last_q == PortI));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (cnt_q == 4'd1) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: grant capture, latency counter, read-data capture and last-grant tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q   <= PortI;
      last_q    <= PortI;
      cnt_q     <= 4'd0;
      m_addr_q  <= '0;
      m_we_q    <= 1'b0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= pick_d;
            if (pick_d) begin
              m_addr_q  <= bus.d_addr;
              m_we_q    <= bus.d_we;
              m_wdata_q <= bus.d_wdata;
            end else begin
              m_addr_q  <= bus.i_addr;
              m_we_q    <= 1'b0;
              m_wdata_q <= '0;
            end
          end
        end
        StIssue: cnt_q <= LatCnt;
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          // Memory data is valid only in the last WAIT cycle; stores keep d_rdata.
          if (cnt_q == 4'd1) begin
            if (grant_q == PortI) begin
              i_rdata_q <= bus.m_rdata;
            end else if (!m_we_q) begin
              d_rdata_q <= bus.m_rdata;
            end
          end
        end
        StResp: last_q <= grant_q;
        default: ;
      endcase
    end
  end

  // Outputs: strobes decode from state so reset clears them immediately.
  always_comb begin
    bus.m_en    = (state_q == StIssue);
    bus.busy    = (state_q != StIdle);
    bus.i_ready = (state_q == StResp) && (grant_q == PortI);
    bus.d_ready = (state_q == StResp) && (grant_q == PortD);
    bus.m_we    = m_we_q;
    bus.m_addr  = m_addr_q;
    bus.m_wdata = m_wdata_q;
    bus.i_rdata = i_rdata_q;
    bus.d_rdata = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: DUT 0 uses LATENCY=2, DUT 1 uses LATENCY=1 and DUT 2 uses LATENCY=4.
// Each DUT has its own read-only memory model that returns data only in the single
// cycle that lies LATENCY cycles after the m_en cycle.
module tb_mem_port_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          NDUT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NDUT-1:0] i_req, d_req, d_we;
  logic [AW-1:0]   i_addr [NDUT];
  logic [AW-1:0]   d_addr [NDUT];
  logic [DW-1:0]   d_wdata[NDUT];
  logic [NDUT-1:0] i_ready, d_ready, m_en, m_we, busy;
  logic [DW-1:0]   i_rdata[NDUT];
  logic [DW-1:0]   d_rdata[NDUT];
  logic [DW-1:0]   m_wdata[NDUT];
  logic [AW-1:0]   m_addr [NDUT];

  function automatic logic [31:0] mem_word(input int unsigned idx);
    if (idx == 0) return 32'h0050_0113;
    return 32'hA500_0000 | (32'(idx) * 32'h0000_0101);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    int unsigned cnt  = 0;
    logic [5:0]  ridx = '0;

    assign bus.i_req   = i_req[g];
    assign bus.i_addr  = i_addr[g];
    assign bus.d_req   = d_req[g];
    assign bus.d_we    = d_we[g];
    assign bus.d_addr  = d_addr[g];
    assign bus.d_wdata = d_wdata[g];
    assign i_ready[g]  = bus.i_ready;
    assign d_ready[g]  = bus.d_ready;
    assign m_en[g]     = bus.m_en;
    assign m_we[g]     = bus.m_we;
    assign busy[g]     = bus.busy;
    assign i_rdata[g]  = bus.i_rdata;
    assign d_rdata[g]  = bus.d_rdata;
    assign m_wdata[g]  = bus.m_wdata;
    assign m_addr[g]   = bus.m_addr;

    always @(posedge clk) begin
      if (bus.m_en) begin
        cnt  <= L;
        ridx <= bus.m_addr[7:2];
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
    assign bus.m_rdata = (cnt == 1) ? mem_word(32'(ridx)) : 32'hBAD0_BAD0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LATENCY(L)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-run event log, cycle numbers relative to the cycle the stimulus was applied in.
  int          men_cyc[$];
  logic [31:0] men_addr[$];
  logic        men_we[$];
  logic [31:0] men_wd[$];
  int          rdy_cyc[$];
  int          rdy_port[$];
  logic [31:0] rdy_data[$];
  int          overlap;
  logic [31:0] i_next[$];
  logic [31:0] d_next[$];

  // Observe one DUT for ncyc cycles at the falling edge. Unless hold is set, a requester
  // moves to its next queued address on ready, or drops req when the queue is empty.
  task automatic run(input int u, input int ncyc, input bit hold);
    men_cyc.delete(); men_addr.delete(); men_we.delete(); men_wd.delete();
    rdy_cyc.delete(); rdy_port.delete(); rdy_data.delete();
    overlap = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (m_en[u]) begin
        men_cyc.push_back(c);
        men_addr.push_back(m_addr[u]);
        men_we.push_back(m_we[u]);
        men_wd.push_back(m_wdata[u]);
      end
      if (i_ready[u] && d_ready[u]) overlap++;
      if (i_ready[u]) begin
        rdy_cyc.push_back(c); rdy_port.push_back(0); rdy_data.push_back(i_rdata[u]);
        if (!hold) begin
          if (i_next.size() > 0) i_addr[u] = i_next.pop_front();
          else i_req[u] = 1'b0;
        end
      end
      if (d_ready[u]) begin
        rdy_cyc.push_back(c); rdy_port.push_back(1); rdy_data.push_back(d_rdata[u]);
        if (!hold) begin
          if (d_next.size() > 0) d_addr[u] = d_next.pop_front();
          else d_req[u] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag, input int u);
    check_eq({tag, " strobes"}, 32'({m_en[u], m_we[u], busy[u], i_ready[u], d_ready[u]}), 32'd0);
    check_eq({tag, " m_addr"},  m_addr[u],  32'd0);
    check_eq({tag, " m_wdata"}, m_wdata[u], 32'd0);
    check_eq({tag, " i_rdata"}, i_rdata[u], 32'd0);
    check_eq({tag, " d_rdata"}, d_rdata[u], 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_req = '0; d_req = '0; d_we = '0;
    for (int u = 0; u < NDUT; u++) begin
      i_addr[u] = '0; d_addr[u] = '0; d_wdata[u] = '0;
    end

    // Reset values.
    #12;
    for (int u = 0; u < NDUT; u++) check_all_zero($sformatf("reset%0d", u), u);
    #10 reset = 1'b0;

    // Single fetch from address 0.
    @(negedge clk);
    i_req[0] = 1'b1; i_addr[0] = 32'd0;
    run(0, 6, 1'b0);
    check_eq("fetch men count", 32'(men_cyc.size()), 32'd1);
    check_eq("fetch men cyc",   32'(men_cyc[0]), 32'd1);
    check_eq("fetch m_addr",    men_addr[0], 32'd0);
    check_eq("fetch m_we",      32'(men_we[0]), 32'd0);
    check_eq("fetch rdy count", 32'(rdy_cyc.size()), 32'd1);
    check_eq("fetch rdy cyc",   32'(rdy_cyc[0]), 32'd4);
    check_eq("fetch rdy port",  32'(rdy_port[0]), 32'd0);
    check_eq("fetch i_rdata",   rdy_data[0], 32'h0050_0113);

    // Tie with last=I: D first, then I.
    i_req[0] = 1'b1; i_addr[0] = 32'd4;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'd8;
    run(0, 11, 1'b0);
    check_eq("tie men count", 32'(men_cyc.size()), 32'd2);
    check_eq("tie D men cyc", 32'(men_cyc[0]), 32'd1);
    check_eq("tie D m_addr",  men_addr[0], 32'd8);
    check_eq("tie I men cyc", 32'(men_cyc[1]), 32'd6);
    check_eq("tie I m_addr",  men_addr[1], 32'd4);
    check_eq("tie rdy count", 32'(rdy_cyc.size()), 32'd2);
    check_eq("tie D rdy cyc", 32'(rdy_cyc[0]), 32'd4);
    check_eq("tie D rdy port", 32'(rdy_port[0]), 32'd1);
    check_eq("tie D data",    rdy_data[0], mem_word(2));
    check_eq("tie I rdy cyc", 32'(rdy_cyc[1]), 32'd9);
    check_eq("tie I rdy port", 32'(rdy_port[1]), 32'd0);
    check_eq("tie I data",    rdy_data[1], mem_word(1));

    // Sustained contention for 40 cycles.
    i_req[0] = 1'b1; i_addr[0] = 32'd12;
    d_req[0] = 1'b1; d_addr[0] = 32'd16;
    run(0, 40, 1'b1);
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    check_eq("cont men count", 32'(men_cyc.size()), 32'd8);
    check_eq("cont rdy count", 32'(rdy_cyc.size()), 32'd8);
    check_eq("cont overlap",   32'(overlap), 32'd0);
    for (int k = 0; k < 8 && k < men_cyc.size() && k < rdy_cyc.size(); k++) begin
      check_eq($sformatf("cont men cyc %0d", k), 32'(men_cyc[k]), 32'(1 + 5 * k));
      check_eq($sformatf("cont m_addr %0d", k), men_addr[k], (k % 2 == 0) ? 32'd16 : 32'd12);
      check_eq($sformatf("cont rdy cyc %0d", k), 32'(rdy_cyc[k]), 32'(4 + 5 * k));
      check_eq($sformatf("cont rdy port %0d", k), 32'(rdy_port[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);

    // Store: d_rdata keeps the last load result (address 16).
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'd100; d_wdata[0] = 32'd25;
    run(0, 6, 1'b0);
    d_we[0] = 1'b0;
    check_eq("store men count", 32'(men_cyc.size()), 32'd1);
    check_eq("store men cyc",   32'(men_cyc[0]), 32'd1);
    check_eq("store m_we",      32'(men_we[0]), 32'd1);
    check_eq("store m_addr",    men_addr[0], 32'd100);
    check_eq("store m_wdata",   men_wd[0], 32'd25);
    check_eq("store rdy cyc",   32'(rdy_cyc[0]), 32'd4);
    check_eq("store rdy port",  32'(rdy_port[0]), 32'd1);
    check_eq("store d_rdata",   rdy_data[0], mem_word(4));

    // Reset during WAIT, then the held fetch is re-issued.
    i_req[0] = 1'b1; i_addr[0] = 32'h40;
    @(negedge clk);
    check_eq("rstw m_en c1", 32'(m_en[0]), 32'd1);
    @(negedge clk);
    check_eq("rstw busy c2", 32'(busy[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("rstw async", 0);
    @(negedge clk);
    check_eq("rstw no ready", 32'({i_ready[0], d_ready[0], busy[0]}), 32'd0);
    reset = 1'b0;
    run(0, 6, 1'b0);
    check_eq("rstw men count", 32'(men_cyc.size()), 32'd1);
    check_eq("rstw men cyc",   32'(men_cyc[0]), 32'd1);
    check_eq("rstw m_addr",    men_addr[0], 32'h40);
    check_eq("rstw rdy cyc",   32'(rdy_cyc[0]), 32'd4);
    check_eq("rstw i_rdata",   rdy_data[0], mem_word(16));

    // LATENCY=1: three back-to-back loads, ready at 3, 7, 11.
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'd20;
    d_next.push_back(32'd24); d_next.push_back(32'd28);
    run(1, 12, 1'b0);
    check_eq("lat1 rdy count", 32'(rdy_cyc.size()), 32'd3);
    for (int k = 0; k < 3 && k < rdy_cyc.size(); k++) begin
      check_eq($sformatf("lat1 rdy cyc %0d", k), 32'(rdy_cyc[k]), 32'(3 + 4 * k));
      check_eq($sformatf("lat1 data %0d", k), rdy_data[k], mem_word(32'(5 + k)));
    end

    // LATENCY=4: two back-to-back loads, ready at 6 and 13.
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'd32;
    d_next.push_back(32'd36);
    run(2, 15, 1'b0);
    check_eq("lat4 rdy count", 32'(rdy_cyc.size()), 32'd2);
    for (int k = 0; k < 2 && k < rdy_cyc.size(); k++) begin
      check_eq($sformatf("lat4 rdy cyc %0d", k), 32'(rdy_cyc[k]), 32'(6 + 7 * k));
      check_eq($sformatf("lat4 data %0d", k), rdy_data[k], mem_word(32'(8 + k)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported, fixed-latency memory between the instruction-fetch port and the data (load/store) port of the `pipelined` core. It replaces the separate instruction and data memories with one unified memory. Each requester holds a request until it receives a one-cycle `ready` pulse. The core stalls the requesting stage while `ready` is low.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `LATENCY`, 2, memory read latency in cycles (legal range 1..15)

Ports:
- `clk`  in  1  clock; everything updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately
- `i_req`  in  1  instruction fetch request; held high until `i_ready`
- `i_addr`  in  AW  fetch address; stable while `i_req` is high
- `i_rdata`  out  DW  fetched instruction; valid in the `i_ready` cycle
- `i_ready`  out  1  one-cycle completion pulse for the fetch
- `d_req`  in  1  data access request; held high until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data; valid in the `d_ready` cycle
- `d_ready`  out  1  one-cycle completion pulse for the data access
- `m_en`  out  1  memory command strobe; high for exactly one cycle per access
- `m_we`  out  1  memory write enable; qualified by `m_en`
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data; valid `LATENCY` cycles after the `m_en` cycle
- `busy`  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `m_en` is high for one cycle.
  - WAIT: countdown of `LATENCY` cycles.
  - RESP: the `ready` pulse.
- IDLE, on a sampling edge:
  - Only `d_req` high: grant D.
  - Only `i_req` high: grant I.
  - Both high: grant the port that was not granted last. The `last` register resets to I, so D wins the first tie.
  - The winner's address, `we` and `wdata` are registered onto the `m_*` outputs. I always registers `m_we=0`. Next state is ISSUE.
- ISSUE: `m_en=1`. Counter is loaded with `LATENCY`. Next state is WAIT.
- WAIT: `m_en=0`; `m_addr`, `m_we` and `m_wdata` hold their values.
  - Counter decrements each cycle.
  - On the last WAIT cycle (counter = 1), `m_rdata` is captured. It goes into `i_rdata` for an I read or `d_rdata` for a D load. Stores leave `d_rdata` unchanged.
  - Next state is RESP.
- RESP: the granted port's `ready` is high for one cycle and `last` is updated. Requests are not sampled in this cycle, because the finishing requester's `req` is still high. Next state is IDLE.
- Stores complete with the same latency and `ready` timing as loads.
- Requests arriving while `busy` is high are queued implicitly by the requester holding `req`. No request is dropped.
- If a requester drops `req` before its `ready`, the in-flight access still completes and still pulses `ready`. The requester ignores that pulse.

## Timing
- Reset values: every output is 0 (`m_en`, `m_we`, `m_addr`, `m_wdata`, `i_rdata`, `d_rdata`, `i_ready`, `d_ready`, `busy`). State is IDLE, `last` is I.
- Let n be the first IDLE cycle in which a request is high:
  - `m_en` is high in cycle n+1.
  - `m_rdata` is captured at the end of cycle n+1+LATENCY.
  - `ready` is high in cycle n+2+LATENCY.
  - The earliest next arbitration is cycle n+3+LATENCY.
- Throughput is one access per LATENCY+3 cycles; with `LATENCY=2` that is one per 5 cycles.
- Reset asserted in ISSUE, WAIT or RESP:
  - All outputs go to 0 asynchronously and no `ready` is produced.
  - The memory may or may not have performed a write whose `m_en` was already sampled.
- After reset is released, arbitration restarts on the first rising edge with a request present.
- `i_ready` and `d_ready` are never high in the same cycle.

## Test plan
- Single fetch: release reset at 22 ns, `i_req=1` with `i_addr=0` from cycle 0, memory returns 0x00500113.
  - Required: `m_en=1` with `m_addr=0`, `m_we=0` in cycle 1 only.
  - Required: `i_ready=1` and `i_rdata=0x00500113` in cycle 4 only.
- Store: `d_req=1`, `d_we=1`, `d_addr=100`, `d_wdata=25`.
  - Required: exactly one cycle with `m_en=1`, `m_we=1`, `m_addr=100`, `m_wdata=25`.
  - Required: `d_ready` pulses 3 cycles later; `d_rdata` is unchanged.
- Tie after reset: `i_req` and `d_req` rise in the same cycle 0.
  - Required: D is issued in cycle 1 and `d_ready` pulses in cycle 4.
  - Required: I is issued in cycle 6 and `i_ready` pulses in cycle 9.
- Sustained contention: both requests held high for 40 cycles.
  - Required: grants alternate D, I, D, I.
  - Required: `m_en` fires every 5 cycles, with no gaps and no two `ready` pulses in the same cycle.
- Reset in WAIT: assert `reset` mid-cycle during WAIT.
  - Required: `busy` and all outputs go to 0 before the next clock edge, with no `ready` pulse.
  - Required: after release, a held `i_req` is re-issued with `m_en` one cycle later.
- Latency sweep: `LATENCY=1` and `LATENCY=4` with back-to-back loads from a preloaded memory.
  - Required: `ready` comes LATENCY+2 cycles after the first request cycle, and the captured data matches memory contents.
